// File: rtl/mem_arb_pkg.sv
// +----------------------------------------------------------------------+
// | mem_arb_pkg: shared types/constants for the RAM bus arbiter          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    RDATA = 2'd2
  } arb_state_e;

  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;

endpackage

`default_nettype wire

// File: rtl/arb_starve_counter.sv
// +----------------------------------------------------------------------+
// | arb_starve_counter: saturating wait counter for port B               |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module arb_starve_counter #(
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam logic [3:0] LIMIT_V = 4'(LIMIT);

  logic [3:0] count_q;
  logic [3:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 4'd0;
    end else if (inc_i && (count_q != LIMIT_V)) begin
      count_d = count_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= 4'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign sat_o = (count_q == LIMIT_V);

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// +----------------------------------------------------------------------+
// | mem_bus_arbiter: two-port arbiter for the single-port 256x16 RAM     |
// | Option: MEM_ARB_STARVE_EN adds B starvation override.  Rev 1.0       |
// +----------------------------------------------------------------------+
`default_nettype none

module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 8,
  parameter int DATA_W       = 16,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_write,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_write,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_en,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              owner
);

  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_limit
    $error("mem_bus_arbiter: STARVE_LIMIT must be 1..15");
  end

  arb_state_e        state_q, state_d;
  logic              owner_q, owner_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              b_starved;
  logic              b_wins;

`ifdef MEM_ARB_STARVE_EN
  arb_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk   (clk),
    .rst_n (rst_n),
    .inc_i (b_req & ~b_gnt),
    .clr_i (b_gnt),
    .sat_o (b_starved)
  );
`else
  assign b_starved = 1'b0;
`endif

  // A keeps priority unless B has waited out the starvation limit.
  assign b_wins = b_req & (~a_req | b_starved);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          state_d = SERVE;
          if (b_wins) begin
            owner_d = OWN_B;
            wr_d    = b_write;
            addr_d  = b_addr;
            wdata_d = b_wdata;
          end else begin
            owner_d = OWN_A;
            wr_d    = a_write;
            addr_d  = a_addr;
            wdata_d = a_wdata;
          end
        end
      end
      SERVE:   state_d = wr_q ? IDLE : RDATA;
      RDATA:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= OWN_A;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  // The latched copy drives the RAM bus directly so it holds between accesses.
  assign mem_en    = (state_q == SERVE);
  assign mem_write = mem_en & wr_q;
  assign mem_addr  = addr_q;
  assign mem_din   = wdata_q;
  assign owner     = owner_q;

  assign a_gnt    = mem_en & (owner_q == OWN_A);
  assign b_gnt    = mem_en & (owner_q == OWN_B);
  assign a_rvalid = (state_q == RDATA) & (owner_q == OWN_A);
  assign b_rvalid = (state_q == RDATA) & (owner_q == OWN_B);
  assign a_rdata  = a_rvalid ? mem_dout : '0;
  assign b_rdata  = b_rvalid ? mem_dout : '0;

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// +----------------------------------------------------------------------+
// | tb_mem_bus_arbiter: randomized scoreboard bench for mem_bus_arbiter  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_mem_bus_arbiter;

  localparam int ADDR_W       = 8;
  localparam int DATA_W       = 16;
  localparam int STARVE_LIMIT = 4;

  typedef struct packed {
    logic        wr;
    logic [7:0]  addr;
    logic [15:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        a_req, a_write, b_req, b_write;
  logic [7:0]  a_addr, b_addr, mem_addr;
  logic [15:0] a_wdata, b_wdata, a_rdata, b_rdata, mem_din, mem_dout;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid, mem_en, mem_write, owner;

  int n_chk = 0;
  int n_fail = 0;

  txn_t        stim_a[$], stim_b[$], pend_a[$], pend_b[$];
  logic [15:0] rexp_a[$], rexp_b[$];
  logic [15:0] ref_mem [256];

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_write(a_write), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_write(b_write), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_en(mem_en), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .owner(owner)
  );

  function automatic logic [15:0] init_val(input int i);
    logic [15:0] v;
    v = 16'(i * 16'h1357) ^ 16'hA5A5;
    if (i == 0) v = 16'hD000;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural single-port RAM: read data appears the cycle after the strobe.
  initial begin : ram_model
    logic [15:0] ram [256];
    for (int i = 0; i < 256; i++) ram[i] = init_val(i);
    mem_dout = 16'h0;
    forever begin
      @(posedge clk);
      if (mem_en) begin
        if (mem_write) ram[mem_addr] = mem_din;
        else           mem_dout <= ram[mem_addr];
      end
    end
  end

  initial begin : drv_a
    txn_t t;
    a_req = 0; a_write = 0; a_addr = 0; a_wdata = 0;
    forever begin
      @(negedge clk); #1;
      if (!rst_n) a_req = 0;
      else if (!a_req || a_gnt) begin
        if (stim_a.size() > 0) begin
          t = stim_a.pop_front();
          a_req = 1; a_write = t.wr; a_addr = t.addr; a_wdata = t.data;
          pend_a.push_back(t);
        end else a_req = 0;
      end
    end
  end

  initial begin : drv_b
    txn_t t;
    b_req = 0; b_write = 0; b_addr = 0; b_wdata = 0;
    forever begin
      @(negedge clk); #1;
      if (!rst_n) b_req = 0;
      else if (!b_req || b_gnt) begin
        if (stim_b.size() > 0) begin
          t = stim_b.pop_front();
          b_req = 1; b_write = t.wr; b_addr = t.addr; b_wdata = t.data;
          pend_b.push_back(t);
        end else b_req = 0;
      end
    end
  end

  // Reference: serialized accesses, one sample opportunity when the bus is free,
  // A wins ties (unless B is starved), write occupies 1 cycle, read 2.
  initial begin : monitor
    int          t, free_t, cnt;
    logic        eg_a, eg_b, erv_a, erv_b, gb_now, starved_m, last_own;
    logic [7:0]  last_addr;
    logic [15:0] last_din, ed;
    txn_t        tx;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    t = 0; free_t = 0; cnt = 0;
    eg_a = 0; eg_b = 0; erv_a = 0; erv_b = 0; last_own = 0;
    last_addr = 0; last_din = 0;
    forever begin
      @(negedge clk); #2;
      t++;
      if (!rst_n) begin
        chk("reset_outputs",
            {a_gnt, a_rvalid, a_rdata, b_gnt, b_rvalid, b_rdata, mem_en, mem_write, owner},
            64'h0);
        chk("reset_bus", {mem_addr, mem_din}, 64'h0);
        free_t = 0; cnt = 0; eg_a = 0; eg_b = 0; erv_a = 0; erv_b = 0;
        last_own = 0; last_addr = 0; last_din = 0;
      end else begin
        chk("a_gnt", a_gnt, eg_a);
        chk("b_gnt", b_gnt, eg_b);
        chk("a_rvalid", a_rvalid, erv_a);
        chk("b_rvalid", b_rvalid, erv_b);
        if (erv_a) begin
          ed = (rexp_a.size() > 0) ? rexp_a.pop_front() : 16'hxxxx;
          chk("a_rdata", a_rdata, ed);
        end else chk("a_rdata_quiet", a_rdata, 0);
        if (erv_b) begin
          ed = (rexp_b.size() > 0) ? rexp_b.pop_front() : 16'hxxxx;
          chk("b_rdata", b_rdata, ed);
        end else chk("b_rdata_quiet", b_rdata, 0);
        chk("mem_en", mem_en, eg_a | eg_b);
        erv_a = 0; erv_b = 0;
        if (eg_a || eg_b) begin
          if (eg_a) begin
            chk("gnt_a_has_request", pend_a.size() > 0, 1);
            tx = (pend_a.size() > 0) ? pend_a.pop_front() : 'x;
          end else begin
            chk("gnt_b_has_request", pend_b.size() > 0, 1);
            tx = (pend_b.size() > 0) ? pend_b.pop_front() : 'x;
          end
          last_own = eg_b;
          chk("mem_addr", mem_addr, tx.addr);
          chk("mem_write", mem_write, tx.wr);
          chk("mem_din", mem_din, tx.data);
          if (tx.wr) ref_mem[tx.addr] = tx.data;
          else if (eg_a) begin rexp_a.push_back(ref_mem[tx.addr]); erv_a = 1; end
          else begin rexp_b.push_back(ref_mem[tx.addr]); erv_b = 1; end
          last_addr = tx.addr; last_din = tx.data;
          free_t = t + (tx.wr ? 1 : 2);
        end else begin
          chk("mem_write_idle", mem_write, 0);
          chk("mem_addr_hold", mem_addr, last_addr);
          chk("mem_din_hold", mem_din, last_din);
        end
        chk("owner", owner, last_own);
        gb_now = eg_b;
`ifdef MEM_ARB_STARVE_EN
        starved_m = (cnt == STARVE_LIMIT);
        if (gb_now) cnt = 0;
        else if (b_req && cnt < STARVE_LIMIT) cnt++;
`else
        starved_m = 1'b0;
        cnt = 0;
`endif
        eg_a = 0; eg_b = 0;
        if (t >= free_t && (a_req || b_req)) begin
          if (b_req && (!a_req || starved_m)) eg_b = 1;
          else eg_a = 1;
          free_t = t + 1000000;
        end
      end
    end
  end

  task automatic drain(input string nm, input int budget);
    logic done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk); #3;
      done = (stim_a.size() == 0) && (stim_b.size() == 0) && (pend_a.size() == 0) &&
             (pend_b.size() == 0) && (rexp_a.size() == 0) && (rexp_b.size() == 0) &&
             !a_req && !b_req && !a_rvalid && !b_rvalid && !mem_en;
    end
    chk(nm, done, 1);
  endtask

  task automatic wait_a_gnt(input string nm);
    logic found;
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      @(negedge clk); #3;
      found = a_gnt;
    end
    chk(nm, found, 1);
  endtask

  function automatic txn_t mk(input logic wr, input logic [7:0] addr, input logic [15:0] d);
    txn_t x;
    x.wr = wr; x.addr = addr; x.data = d;
    return x;
  endfunction

  initial begin : main
    int nb;
    repeat (3) @(negedge clk);
    #3 rst_n = 1;

    // Read of preloaded word at 0x00
    stim_a.push_back(mk(1'b0, 8'h00, 16'h1111));
    drain("t1_drain", 50);

    // B write then read-back of 0x14
    stim_b.push_back(mk(1'b1, 8'h14, 16'h0352));
    stim_b.push_back(mk(1'b0, 8'h14, 16'h0000));
    drain("t2_drain", 50);

    // Simultaneous reads from both ports
    stim_a.push_back(mk(1'b0, 8'h14, 16'h0));
    stim_b.push_back(mk(1'b0, 8'h00, 16'h0));
    drain("t3_drain", 50);

    // B request rising during A's read-data cycle
    stim_a.push_back(mk(1'b0, 8'h21, 16'h0));
    wait_a_gnt("t6_a_gnt_seen");
    stim_b.push_back(mk(1'b0, 8'h22, 16'h0));
    drain("t6_drain", 50);

    // A streams back-to-back reads while B holds one request
    for (int i = 0; i < 8; i++) stim_a.push_back(mk(1'b0, 8'(i), 16'(i)));
    stim_b.push_back(mk(1'b1, 8'h30, 16'hBEEF));
    drain("t4_drain", 200);

    // Reset during the SERVE cycle of an A read
    stim_a.push_back(mk(1'b0, 8'h05, 16'h0));
    wait_a_gnt("t5_a_gnt_seen");
    rst_n = 0;
    #1;
    chk("t5_mem_en_drop", mem_en, 0);
    chk("t5_a_gnt_drop", a_gnt, 0);
    stim_a.delete(); stim_b.delete(); pend_a.delete(); pend_b.delete();
    rexp_a.delete(); rexp_b.delete();
    repeat (2) @(negedge clk);
    #3 rst_n = 1;
    repeat (4) @(negedge clk);
    stim_b.push_back(mk(1'b0, 8'h30, 16'h0));
    drain("t5_post_drain", 50);

    // Randomized bursts over a small address window to provoke hazards
    for (int k = 0; k < 80; k++) begin
      nb = $urandom_range(1, 4);
      for (int j = 0; j < nb; j++) begin
        if ($urandom_range(0, 1) == 0)
          stim_a.push_back(mk(1'($urandom), 8'($urandom_range(0, 15)), 16'($urandom)));
        else
          stim_b.push_back(mk(1'($urandom), 8'($urandom_range(0, 15)), 16'($urandom)));
      end
      repeat ($urandom_range(0, 6)) @(negedge clk);
      #3;
    end
    drain("rand_drain", 5000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
